// File: rtl/vect_pkg.sv
// Shared types for the vector data path: lane geometry and the vector word.
// Provides LANES, LANE_W and vec_t (one 48-bit vector of byte lanes).
package vect_pkg;

    localparam int LANES  = 6;
    localparam int LANE_W = 8;

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

endpackage

// File: rtl/data_mem_vect.sv
// Vector data memory: DEPTH entries of one vec_t each, synchronous write,
// combinational read. Ports: clk, rst (sync, active-high), WE, A (byte addr), WD, RD.
module data_mem_vect
    import vect_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [31:0] A,
    input  vec_t        WD,
    output vec_t        RD
);

    localparam int IDX_W = $clog2(DEPTH);

    vec_t             mem [DEPTH];
    logic [IDX_W-1:0] idx;

    // Entry stride is 4 bytes; low bits and high bits are dropped so any
    // address maps to a valid entry (wraps modulo 4*DEPTH).
    assign idx = A[IDX_W+1:2];

    logic unused_addr;
    assign unused_addr = ^{A[31:IDX_W+2], A[1:0]};

    // Reset clears every entry and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE) begin
            mem[idx] <= WD;
        end
    end

    // No write-through: RD shows stored contents only.
    assign RD = mem[idx];

endmodule

// File: tb/tb_data_mem_vect.sv
// Self-checking bench for data_mem_vect against an address-arithmetic model.
// Directed scenarios from the test plan plus a randomized read/write run.
module tb_data_mem_vect;
    import vect_pkg::*;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        WE;
    logic [31:0] A;
    vec_t        WD;
    vec_t        RD;

    int checks;
    int errors;

    logic [47:0] mdl [DEPTH];

    data_mem_vect #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .WE (WE),
        .A  (A),
        .WD (WD),
        .RD (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    // Apply one rising edge and update the model by the spec's rules.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        end else if (WE) begin
            mdl[slot(A)] = WD;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [5];
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        @(negedge clk);
        rst = 1'b1;
        WE  = 1'b0;
        A   = 32'h0;
        WD  = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = addrs[i];
            #1;
            checks++;
            if (RD !== 48'h0) begin
                errors++;
                $display("FAIL reset_sweep A=%h got=%h want=%h", A, RD, 48'h0);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] addrs [6];
        logic [47:0] exp;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h00};
        @(negedge clk);
        WE = 1'b1;
        A  = 32'h00;
        WD = 48'h001122334455;
        tick();
        WE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            A = addrs[i];
            #1;
            exp = (addrs[i] == 32'h00) ? 48'h001122334455 : 48'h0;
            checks++;
            if (RD !== exp) begin
                errors++;
                $display("FAIL write_readback A=%h got=%h want=%h", A, RD, exp);
            end
        end
    endtask

    task automatic test_align_wrap();
        logic [31:0] addrs [4];
        logic [47:0] exp;
        addrs = '{32'h05, 32'h07, 32'h04 + 32'(4 * DEPTH), 32'h08};
        @(negedge clk);
        WE = 1'b1;
        A  = 32'h04;
        WD = 48'hAABBCCDDEEFF;
        tick();
        WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = addrs[i];
            #1;
            exp = (i < 3) ? 48'hAABBCCDDEEFF : 48'h0;
            checks++;
            if (RD !== exp) begin
                errors++;
                $display("FAIL align_wrap A=%h got=%h want=%h", A, RD, exp);
            end
        end
    endtask

    task automatic test_rdw();
        @(negedge clk);
        A  = 32'h00;
        WE = 1'b1;
        WD = 48'h010203040506;
        #1;
        checks++;
        if (RD !== 48'h001122334455) begin
            errors++;
            $display("FAIL rdw_before got=%h want=%h", RD, 48'h001122334455);
        end
        tick();
        WE = 1'b0;
        checks++;
        if (RD !== 48'h010203040506) begin
            errors++;
            $display("FAIL rdw_after got=%h want=%h", RD, 48'h010203040506);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1;
        WE  = 1'b1;
        A   = 32'h00;
        WD  = '1;
        tick();
        rst = 1'b0;
        WE  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            A = 32'(i * 4);
            #1;
            checks++;
            if (RD !== 48'h0) begin
                errors++;
                $display("FAIL reset_priority A=%h got=%h want=%h", A, RD, 48'h0);
            end
        end
    endtask

    task automatic test_we_hold();
        @(negedge clk);
        WE = 1'b1;
        A  = 32'h00;
        WD = 48'h665544332211;
        tick();
        WE = 1'b0;
        WD = 48'h123456789ABC;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (RD !== 48'h665544332211) begin
                errors++;
                $display("FAIL we_hold edge=%0d got=%h want=%h", i, RD, 48'h665544332211);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            WE  = $urandom_range(0, 1) == 1;
            // Bias toward a few entries so reads hit written data.
            if ($urandom_range(0, 3) == 0)
                A = $urandom;
            else
                A = {$urandom_range(0, 15), 2'($urandom)} + (32'($urandom_range(0, 3)) << 10);
            WD = {16'($urandom), $urandom};
            #1;
            checks++;
            if (RD !== mdl[slot(A)]) begin
                errors++;
                $display("FAIL rand_pre n=%0d A=%h got=%h want=%h", n, A, RD, mdl[slot(A)]);
            end
            tick();
            checks++;
            if (RD !== mdl[slot(A)]) begin
                errors++;
                $display("FAIL rand_post n=%0d A=%h got=%h want=%h", n, A, RD, mdl[slot(A)]);
            end
        end
        rst = 1'b0;
        WE  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        WE  = 1'b0;
        A   = '0;
        WD  = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        test_reset();
        test_write_readback();
        test_align_wrap();
        test_rdw();
        test_reset_priority();
        test_we_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_vect.md
Name: data_mem_vect

Overview:
- Vector data memory for the vectorial CPU.
- Each entry is one vector of 6 byte lanes (48 bits), read and written as a whole.
- Synchronous write on `clk`; asynchronous (combinational) read.
- Serves vector load/store instructions from the memory stage.

Parameters:
- LANES, 6, number of byte lanes per vector entry.
- LANE_W, 8, bits per lane.
- DEPTH, 256, number of vector entries; power of two, at least 2.
- IDX_W, $clog2(DEPTH), entry index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- WE  input  1  write enable; sampled on the rising edge of `clk`.
- A  input  32  byte address; entry stride is 4.
- WD  input  [LANES-1:0][LANE_W-1:0]  write data vector.
- RD  output  [LANES-1:0][LANE_W-1:0]  read data vector.

Behaviour:
- Index decode:
  - idx = A[IDX_W+1:2].
  - A[1:0] ignored; no misalignment fault.
  - A[31:IDX_W+2] ignored, so addresses wrap modulo 4*DEPTH.
- Read:
  - RD = mem[idx], purely combinational, zero latency.
  - RD follows changes on A within the same cycle, with no clock edge required.
- Write:
  - On a rising `clk` edge with rst=0 and WE=1: mem[idx] <= WD.
  - All lanes are written together; there are no per-lane enables.
  - Lane k of WD goes to lane k of the entry; lane order is preserved on read.
  - WE=0: memory unchanged.
- Read-during-write, same index:
  - Before the edge, RD shows the old contents.
  - After the edge, RD shows WD.
  - No write-through bypass.
- Reset:
  - On a rising `clk` edge with rst=1, every entry is cleared to 0.
  - After reset, RD = 0 for every address.
  - Reset has priority over a simultaneous write; WD is discarded.
  - Reset asserted mid-sequence discards all previously written data.
- RD has no reset value of its own; it always reflects memory contents.
- Contents before the first reset are unspecified; a bench must reset first.
- No X propagation from A: every 32-bit A value maps to a valid index.

Decomposition:
- Shared package `vect_pkg`:
  - Constants LANES=6, LANE_W=8.
  - `typedef logic [LANES-1:0][LANE_W-1:0] vec_t;`
  - Used for WD, RD, and the memory element type.
- Single module, no sub-modules.
  - Storage is an array `vec_t mem [DEPTH]`.
  - Index decode is a local continuous assignment.
  - Implemented with an `always_ff` for reset/write and an `assign` for read.

Test Plan:
- Reset then read sweep: pulse rst for 1 cycle, then A=0x00,0x04,0x08,0x0C,0x10 with WE=0 -> RD=0 at each address.
- Write then readback: WE=1, A=0x00, WD lanes[5..0]={00,11,22,33,44,55}, one clk edge; then WE=0 with no further clk edges:
  - A=0x00 -> RD lanes[5..0]={00,11,22,33,44,55}.
  - A=0x04/0x08/0x0C/0x10 -> RD=0.
  - Back to A=0x00 -> original vector again.
- Alignment and wrap:
  - Write {AA,BB,CC,DD,EE,FF} at A=0x04.
  - Read A=0x05, 0x07 -> same vector.
  - Read A=0x04+4*DEPTH (0x404 at default) -> same vector.
  - Read A=0x08 -> 0.
- Read-during-write: RD holds {00,11,22,33,44,55} at A=0x00, then WE=1 with WD={01,02,03,04,05,06}:
  - RD unchanged before the edge.
  - RD={01,02,03,04,05,06} immediately after the edge.
- Reset priority: rst=1 and WE=1 with WD={FF..FF} at A=0x00 on the same edge -> RD=0 at A=0x00 and at previously written A=0x04.
- WE low hold: WE=0, WD={12,34,56,78,9A,BC}, several clk edges at A=0x00 -> contents unchanged from the prior value.
